// File: rtl/beamformer_sequencer.sv
// Run sequencer for the 8-channel delay beamformer: RAM readout, filter, flush,
// 4-slice beam frames, summed output stream and go/busy/done handshake.
//
// state  | meaning
// IDLE   | waiting for go, all controls low
// LOAD   | one cycle of channel clear before filtering
// FILTER | stream signal RAM 0..NUM_SAMPLES-1 into the channels
// FLUSH  | let the channel filters drain for FILTER_FLUSH cycles
// BEAM   | 4-slice frames, one per output point
// SUM    | read every output point out of the channels
// DRAIN  | wait for the last sum to leave the pipeline
// DONE   | one-cycle done pulse
module beamformer_sequencer #(
  parameter int          NUM_SAMPLES     = 2048,
  parameter int          FILTER_FLUSH    = 6,
  parameter int          NUM_OUTPUTS     = 540,
  parameter logic [15:0] SAMPLE_IDX_INIT = 16'hFFFE,
  parameter int          READ_LAT        = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  output logic         busy,
  output logic         done,
  output logic [10:0]  sig_addr,
  output logic         sig_rden,
  output logic         ch_rst,
  output logic         ch_start,
  output logic [10:0]  readin_addr,
  output logic [9:0]   sumout_addr,
  output logic         output_read_en,
  output logic         startbeamformer,
  output logic         sumouten,
  output logic [15:0]  sample_index,
  output logic [1:0]   slice_state,
  input  logic [255:0] ch_values,
  output logic         sum_valid,
  output logic [35:0]  sum_data,
  output logic [9:0]   sum_addr
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FILTER, S_FLUSH, S_BEAM, S_SUM, S_DRAIN, S_DONE
  } state_t;

  localparam logic [10:0] LAST_SIG   = 11'(NUM_SAMPLES - 1);
  localparam logic [9:0]  LAST_OUT   = 10'(NUM_OUTPUTS - 1);
  localparam logic [7:0]  FLUSH_LOAD = 8'(FILTER_FLUSH - 1);
  localparam logic [7:0]  DRAIN_LOAD = 8'(READ_LAT);

  state_t      state_q, state_d;
  logic [10:0] sig_addr_q, sig_addr_d;
  logic [10:0] readin_addr_q, readin_addr_d;
  logic [9:0]  sumout_addr_q, sumout_addr_d;
  logic [1:0]  slice_q, slice_d;
  logic [15:0] sample_index_q, sample_index_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [READ_LAT-1:0]       en_pipe_q, en_pipe_d;
  logic [READ_LAT-1:0][9:0]  addr_pipe_q, addr_pipe_d;
  logic                      sum_valid_q, sum_valid_d;
  logic [35:0]               sum_data_q, sum_data_d;
  logic [9:0]                sum_addr_q, sum_addr_d;
  logic [35:0]               ch_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      sig_addr_q     <= '0;
      readin_addr_q  <= '0;
      sumout_addr_q  <= '0;
      slice_q        <= '0;
      sample_index_q <= SAMPLE_IDX_INIT;
      cnt_q          <= '0;
      en_pipe_q      <= '0;
      addr_pipe_q    <= '0;
      sum_valid_q    <= 1'b0;
      sum_data_q     <= '0;
      sum_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      sig_addr_q     <= sig_addr_d;
      readin_addr_q  <= readin_addr_d;
      sumout_addr_q  <= sumout_addr_d;
      slice_q        <= slice_d;
      sample_index_q <= sample_index_d;
      cnt_q          <= cnt_d;
      en_pipe_q      <= en_pipe_d;
      addr_pipe_q    <= addr_pipe_d;
      sum_valid_q    <= sum_valid_d;
      sum_data_q     <= sum_data_d;
      sum_addr_q     <= sum_addr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    sig_addr_d      = sig_addr_q;
    readin_addr_d   = readin_addr_q;
    sumout_addr_d   = sumout_addr_q;
    slice_d         = slice_q;
    sample_index_d  = sample_index_q;
    cnt_d           = cnt_q;
    done            = 1'b0;
    sig_rden        = 1'b0;
    ch_rst          = 1'b0;
    ch_start        = 1'b0;
    output_read_en  = 1'b0;
    startbeamformer = 1'b0;
    sumouten        = 1'b0;
    case (state_q)
      S_IDLE: begin
        sample_index_d = SAMPLE_IDX_INIT;
        if (go) state_d = S_LOAD;
      end
      S_LOAD: begin
        sig_rden   = 1'b1;
        ch_rst     = 1'b1;
        sig_addr_d = '0;
        state_d    = S_FILTER;
      end
      S_FILTER: begin
        sig_rden = 1'b1;
        ch_start = 1'b1;
        ch_rst   = 1'b1;
        if (sig_addr_q == LAST_SIG) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else begin
          sig_addr_d = sig_addr_q + 11'd1;
        end
      end
      S_FLUSH: begin
        ch_start = 1'b1;
        ch_rst   = 1'b1;
        if (cnt_q == 8'd0) begin
          state_d       = S_BEAM;
          readin_addr_d = '0;
          sumout_addr_d = '0;
          slice_d       = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_BEAM: begin
        startbeamformer = 1'b1;
        output_read_en  = 1'b1;
        slice_d         = slice_q + 2'd1;
        // slice 0 of every frame reuses the index left by the previous frame
        if (slice_q != 2'd0) sample_index_d = sample_index_q + 16'd1;
        if (slice_q == 2'd3) begin
          readin_addr_d = readin_addr_q + 11'd1;
          if (sumout_addr_q == LAST_OUT) begin
            sumout_addr_d = '0;
            slice_d       = '0;
            state_d       = S_SUM;
          end else begin
            sumout_addr_d = sumout_addr_q + 10'd1;
          end
        end
      end
      S_SUM: begin
        sumouten = 1'b1;
        if (sumout_addr_q == LAST_OUT) begin
          sumout_addr_d = '0;
          state_d       = S_DRAIN;
          cnt_d         = DRAIN_LOAD;
        end else begin
          sumout_addr_d = sumout_addr_q + 10'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == 8'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_DONE: begin
        done           = 1'b1;
        state_d        = S_IDLE;
        sig_addr_d     = '0;
        readin_addr_d  = '0;
        sumout_addr_d  = '0;
        slice_d        = '0;
        sample_index_d = SAMPLE_IDX_INIT;
        cnt_d          = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Enable/address ride alongside the channel RAM read latency, then one adder stage.
  always_comb begin
    en_pipe_d      = en_pipe_q;
    addr_pipe_d    = addr_pipe_q;
    en_pipe_d[0]   = sumouten;
    addr_pipe_d[0] = sumout_addr_q;
    for (int i = 1; i < READ_LAT; i++) begin
      en_pipe_d[i]   = en_pipe_q[i-1];
      addr_pipe_d[i] = addr_pipe_q[i-1];
    end
    ch_sum = '0;
    for (int k = 0; k < 8; k++) begin
      ch_sum = ch_sum + {{4{ch_values[32*k+31]}}, ch_values[32*k +: 32]};
    end
    sum_valid_d = en_pipe_q[READ_LAT-1];
    sum_data_d  = en_pipe_q[READ_LAT-1] ? ch_sum : sum_data_q;
    sum_addr_d  = en_pipe_q[READ_LAT-1] ? addr_pipe_q[READ_LAT-1] : sum_addr_q;
  end

  assign busy         = (state_q != S_IDLE);
  assign sig_addr     = sig_addr_q;
  assign readin_addr  = readin_addr_q;
  assign sumout_addr  = sumout_addr_q;
  assign slice_state  = slice_q;
  assign sample_index = sample_index_q;
  assign sum_valid    = sum_valid_q;
  assign sum_data     = sum_data_q;
  assign sum_addr     = sum_addr_q;

endmodule

// File: tb/tb_beamformer_sequencer.sv
// Bench for beamformer_sequencer: channel RAM model driven from a value table,
// expected sums and run timing derived from the run description.
module tb_beamformer_sequencer;

  localparam int RUN_LEN = 1 + 2048 + 6 + 2160 + 540 + 2 + 1;
  localparam int NOUT    = 540;

  logic         clk = 1'b0;
  logic         rst;
  logic         go;
  logic         busy, done, sig_rden, ch_rst, ch_start, output_read_en;
  logic         startbeamformer, sumouten, sum_valid;
  logic [10:0]  sig_addr, readin_addr;
  logic [9:0]   sumout_addr, sum_addr;
  logic [15:0]  sample_index;
  logic [1:0]   slice_state;
  logic [255:0] ch_values;
  logic [35:0]  sum_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:NOUT-1][0:7];
  logic [35:0] exp_sum [0:NOUT-1];
  logic [9:0]  beat_addr [$];
  logic [35:0] beat_data [$];
  int busy_cnt, done_cnt, hit_last;
  bit timed_out;
  logic [9:0] addr_s = '0;

  beamformer_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done),
    .sig_addr(sig_addr), .sig_rden(sig_rden), .ch_rst(ch_rst), .ch_start(ch_start),
    .readin_addr(readin_addr), .sumout_addr(sumout_addr),
    .output_read_en(output_read_en), .startbeamformer(startbeamformer),
    .sumouten(sumouten), .sample_index(sample_index), .slice_state(slice_state),
    .ch_values(ch_values), .sum_valid(sum_valid), .sum_data(sum_data),
    .sum_addr(sum_addr)
  );

  always #5 clk = ~clk;

  // Channel output RAM: one cycle from sumout_addr to ch_values.
  always @(negedge clk) addr_s = sumout_addr;
  always @(posedge clk) begin
    logic [255:0] v;
    #1;
    v = '0;
    if (int'(addr_s) < NOUT)
      for (int k = 0; k < 8; k++) v[32*k +: 32] = mem[addr_s][k];
    ch_values = v;
  end

  task automatic fill_table(input int mode);
    int mixed [8] = '{5, -3, 0, 7, -1, 2, -10, 1};
    for (int a = 0; a < NOUT; a++)
      for (int k = 0; k < 8; k++)
        case (mode)
          0: mem[a][k] = 32'h0;
          1: mem[a][k] = 32'h7FFFFFFF;
          2: mem[a][k] = 32'hFFFFFFFF;
          3: mem[a][k] = 32'(mixed[k]);
          default: mem[a][k] = $urandom;
        endcase
    for (int a = 0; a < NOUT; a++) begin
      longint acc = 0;
      for (int k = 0; k < 8; k++) acc += longint'($signed(mem[a][k]));
      exp_sum[a] = acc[35:0];
    end
  endtask

  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  // Runs one go..done sequence collecting timing statistics and output beats.
  task automatic run_capture(input bit rep_filter, input bit rep_sum);
    logic [10:0] prev;
    busy_cnt = 0; done_cnt = 0; hit_last = 0; timed_out = 1'b1;
    beat_addr.delete(); beat_data.delete();
    prev = sig_addr;
    pulse_go();
    for (int c = 0; c < 7000; c++) begin
      @(negedge clk);
      go = 1'b0;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (sig_addr == 11'd2047 && prev != 11'd2047) hit_last++;
      prev = sig_addr;
      if (sum_valid) begin
        beat_addr.push_back(sum_addr);
        beat_data.push_back(sum_data);
      end
      if (rep_filter && sig_rden && ch_start && sig_addr == 11'd100) go = 1'b1;
      if (rep_sum && sumouten && sumout_addr == 10'd100) go = 1'b1;
      if (!busy && busy_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, sig_rden, ch_rst, ch_start, output_read_en, startbeamformer,
         sumouten, sum_valid} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0", {busy, done, sig_rden, ch_rst, ch_start,
               output_read_en, startbeamformer, sumouten, sum_valid});
    end
    checks++;
    if ({sig_addr, readin_addr, sumout_addr, slice_state} !== 34'b0) begin
      errors++;
      $display("FAIL reset_addr: sig %h rin %h sout %h slice %h want 0",
               sig_addr, readin_addr, sumout_addr, slice_state);
    end
    checks++;
    if (sample_index !== 16'hFFFE) begin
      errors++;
      $display("FAIL reset_sidx: got %h want fffe", sample_index);
    end
    checks++;
    if ({sum_data, sum_addr} !== 46'b0) begin
      errors++;
      $display("FAIL reset_sum: data %h addr %h want 0", sum_data, sum_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_run();
    fill_table(0);
    run_capture(1'b0, 1'b0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL full_timeout: run did not end"); end
    checks++;
    if (busy_cnt != RUN_LEN) begin
      errors++; $display("FAIL full_busy: got %0d want %0d", busy_cnt, RUN_LEN);
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL full_done: got %0d want 1", done_cnt); end
    checks++;
    if (hit_last != 1) begin errors++; $display("FAIL full_sig_last: got %0d want 1", hit_last); end
    checks++;
    if (beat_addr.size() != NOUT) begin
      errors++; $display("FAIL full_beats: got %0d want %0d", beat_addr.size(), NOUT);
    end
    for (int i = 0; i < beat_addr.size() && i < NOUT; i++) begin
      checks++;
      if (beat_addr[i] !== 10'(i) || beat_data[i] !== exp_sum[i]) begin
        errors++;
        $display("FAIL full_beat[%0d]: addr %0d data %h want addr %0d data %h",
                 i, beat_addr[i], beat_data[i], i, exp_sum[i]);
      end
    end
  endtask

  task automatic test_beam_slices();
    bit found = 1'b0;
    fill_table(0);
    pulse_go();
    for (int c = 0; c < 5000 && !found; c++) begin
      @(negedge clk);
      if (startbeamformer) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL beam_start: BEAM never reached"); end
    for (int i = 0; i < 12 && found; i++) begin
      int f = i / 4;
      int s = i % 4;
      logic [15:0] e_idx = 16'hFFFE + 16'(3 * f + ((s == 0) ? 0 : s - 1));
      checks++;
      if (slice_state !== 2'(s) || sample_index !== e_idx || readin_addr !== 11'(f) ||
          !output_read_en || ch_rst || ch_start) begin
        errors++;
        $display("FAIL beam_trace[%0d]: slice %0d sidx %h rin %0d ore %b rst %b st %b want slice %0d sidx %h rin %0d 1 0 0",
                 i, slice_state, sample_index, readin_addr, output_read_en, ch_rst, ch_start,
                 s, e_idx, f);
      end
      @(negedge clk);
    end
    found = 1'b0;
    for (int c = 0; c < 5000 && !found; c++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL beam_end: run did not end"); end
  endtask

  task automatic test_arith();
    for (int mode = 1; mode <= 4; mode++) begin
      int bad = 0;
      fill_table(mode);
      run_capture(1'b0, 1'b0);
      checks++;
      if (timed_out || beat_addr.size() != NOUT) begin
        errors++;
        $display("FAIL arith_beats mode %0d: got %0d beats timeout %0d want %0d",
                 mode, beat_addr.size(), timed_out, NOUT);
      end
      for (int i = 0; i < beat_addr.size() && i < NOUT; i++) begin
        checks++;
        if (beat_addr[i] !== 10'(i) || beat_data[i] !== exp_sum[i]) begin
          errors++;
          if (bad++ < 5)
            $display("FAIL arith mode %0d beat %0d: addr %0d data %h want addr %0d data %h",
                     mode, i, beat_addr[i], beat_data[i], i, exp_sum[i]);
        end
      end
    end
  endtask

  task automatic test_go_ignored();
    fill_table(0);
    run_capture(1'b1, 1'b1);
    checks++;
    if (timed_out || busy_cnt != RUN_LEN) begin
      errors++; $display("FAIL go_busy: got %0d want %0d", busy_cnt, RUN_LEN);
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL go_done: got %0d want 1", done_cnt); end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL go_restart: busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid_beam();
    bit found = 1'b0;
    bit saw_done = 1'b0;
    fill_table(4);
    pulse_go();
    for (int c = 0; c < 5000 && !found; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (startbeamformer && readin_addr == 11'd100) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_frame: frame 100 never reached"); end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, sig_rden, ch_rst, ch_start, output_read_en, startbeamformer,
         sumouten, sum_valid, sig_addr, readin_addr, sumout_addr, slice_state} !== 43'b0 ||
        sample_index !== 16'hFFFE || saw_done) begin
      errors++;
      $display("FAIL mid_reset: busy %b sb %b sig %h rin %h sout %h slice %h sidx %h done_seen %b want zeros sidx fffe",
               busy, startbeamformer, sig_addr, readin_addr, sumout_addr, slice_state,
               sample_index, saw_done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_capture(1'b0, 1'b0);
    checks++;
    if (timed_out || busy_cnt != RUN_LEN || done_cnt != 1) begin
      errors++;
      $display("FAIL mid_rerun: busy %0d done %0d want %0d 1", busy_cnt, done_cnt, RUN_LEN);
    end
    checks++;
    if (beat_addr.size() != NOUT || beat_data[NOUT-1] !== exp_sum[NOUT-1]) begin
      errors++;
      $display("FAIL mid_rerun_beats: got %0d beats want %0d", beat_addr.size(), NOUT);
    end
  endtask

  initial begin
    ch_values = '0;
    test_reset();
    test_full_run();
    test_beam_slices();
    test_arith();
    test_go_ignored();
    test_reset_mid_beam();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
